// File: rtl/atm_account_controller.sv
// Account transaction engine: one withdraw/deposit/inquiry at a time against the
// account-record RAM (read, check, write back, respond), fixed four-edge latency.
`timescale 1ns/1ps
module atm_account_controller #(
    parameter int FINAL_UP_LIMIT_WIDTH   = 15,
    parameter int AVAILABLE_CREDIT_WIDTH = 25,
    parameter int RAM_DATA_WIDTH         = FINAL_UP_LIMIT_WIDTH + AVAILABLE_CREDIT_WIDTH,
    parameter int RAM_MEM_SIZE           = 64,
    localparam int LW = FINAL_UP_LIMIT_WIDTH,
    localparam int CW = AVAILABLE_CREDIT_WIDTH,
    localparam int AW = $clog2(RAM_MEM_SIZE)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      req_valid,
    output logic                      req_ready,
    input  logic [1:0]                req_op,
    input  logic [AW-1:0]             req_acct,
    input  logic [CW-1:0]             req_amount,
    output logic                      resp_valid,
    input  logic                      resp_ready,
    output logic [1:0]                resp_status,
    output logic [CW-1:0]             resp_balance,
    output logic                      ram_write_enable,
    output logic [AW-1:0]             ram_address,
    output logic [RAM_DATA_WIDTH-1:0] ram_data_in,
    input  logic [RAM_DATA_WIDTH-1:0] ram_data_out
);

    localparam logic [1:0] OP_WD = 2'b00, OP_DEP = 2'b01, OP_INQ = 2'b10;
    localparam logic [1:0] ST_OK = 2'b00, ST_INSUF = 2'b01, ST_OVER = 2'b10, ST_ERR = 2'b11;

    typedef enum logic [2:0] {S_IDLE, S_READ, S_CHECK, S_WRITE, S_RESP} state_t;

    state_t                    state_q, state_d;
    logic [1:0]                op_q;
    logic [AW-1:0]             acct_q;
    logic [CW-1:0]             amount_q;
    logic [RAM_DATA_WIDTH-1:0] rec_q;
    logic [1:0]                status_q;
    logic [CW-1:0]             new_credit_q;
    logic                      wr_ok;

    // Returns {status, credit after transaction}; rejected requests keep the stored credit.
    function automatic logic [CW+1:0] check_txn(input logic [1:0]    op,
                                                input logic [LW-1:0] limit,
                                                input logic [CW-1:0] credit,
                                                input logic [CW-1:0] amount);
        logic [CW:0] sum;
        sum       = {1'b0, credit} + {1'b0, amount};
        check_txn = {ST_ERR, credit};
        case (op)
            OP_WD: begin
                if (amount > CW'(limit))  check_txn = {ST_OVER, credit};
                else if (amount > credit) check_txn = {ST_INSUF, credit};
                else                      check_txn = {ST_OK, credit - amount};
            end
            OP_DEP: begin
                if (sum[CW]) check_txn = {ST_ERR, credit};
                else         check_txn = {ST_OK, sum[CW-1:0]};
            end
            OP_INQ:  check_txn = {ST_OK, credit};
            default: check_txn = {ST_ERR, credit};
        endcase
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    // Datapath registers carry no reset; every output that exposes them is gated by state.
    always_ff @(posedge clk) begin
        if (state_q == S_IDLE && req_valid) begin
            op_q     <= req_op;
            acct_q   <= req_acct;
            amount_q <= req_amount;
        end
        if (state_q == S_READ) rec_q <= ram_data_out;
        if (state_q == S_CHECK)
            {status_q, new_credit_q} <= check_txn(op_q, rec_q[RAM_DATA_WIDTH-1:CW],
                                                  rec_q[CW-1:0], amount_q);
    end

    assign wr_ok = (status_q == ST_OK) && (op_q == OP_WD || op_q == OP_DEP);

    always_comb begin
        state_d          = state_q;
        req_ready        = 1'b0;
        resp_valid       = 1'b0;
        resp_status      = '0;
        resp_balance     = '0;
        ram_write_enable = 1'b0;
        ram_address      = '0;
        ram_data_in      = '0;
        case (state_q)
            S_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) state_d = S_READ;
            end
            S_READ: begin
                ram_address = acct_q;
                state_d     = S_CHECK;
            end
            S_CHECK: state_d = S_WRITE;
            S_WRITE: begin
                ram_address      = acct_q;
                ram_write_enable = wr_ok;
                ram_data_in      = {rec_q[RAM_DATA_WIDTH-1:CW], new_credit_q};
                state_d          = S_RESP;
            end
            S_RESP: begin
                resp_valid   = 1'b1;
                resp_status  = status_q;
                resp_balance = new_credit_q;
                if (resp_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_atm_account_controller.sv
// Bench for atm_account_controller: behavioural account model, per-cycle compare
// process, directed account scenarios and randomized transactions.
`timescale 1ns/1ps
module tb_atm_account_controller;

    localparam int  NACCT  = 64;
    localparam longint CMAX = 64'd33554431;  // 2^25-1

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic [1:0]  req_op;
    logic [5:0]  req_acct;
    logic [24:0] req_amount;
    logic        resp_valid;
    logic        resp_ready;
    logic [1:0]  resp_status;
    logic [24:0] resp_balance;
    logic        ram_write_enable;
    logic [5:0]  ram_address;
    logic [39:0] ram_data_in;
    logic [39:0] ram_data_out;

    atm_account_controller dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_acct(req_acct), .req_amount(req_amount),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_status(resp_status), .resp_balance(resp_balance),
        .ram_write_enable(ram_write_enable), .ram_address(ram_address),
        .ram_data_in(ram_data_in), .ram_data_out(ram_data_out)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Account model: limit and credit per account (committed when the write lands).
    logic [14:0] lim  [NACCT];
    logic [24:0] cred [NACCT];

    // RAM: combinational read, write on the clock edge.
    logic [39:0] mem [NACCT];
    logic        preload;
    assign ram_data_out = mem[ram_address];
    always @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < NACCT; i++) mem[i] <= {lim[i], cred[i]};
        end else if (ram_write_enable) begin
            mem[ram_address] <= ram_data_in;
        end
    end

    function automatic void model_txn(input int op, input int a, input longint amt,
                                      output int st, output longint bal, output bit wr);
        longint c = longint'(cred[a]);
        longint l = longint'(lim[a]);
        wr  = 1'b0;
        bal = c;
        st  = 3;
        if (op == 0) begin
            if (amt > l)      st = 2;
            else if (amt > c) st = 1;
            else begin st = 0; bal = c - amt; wr = 1'b1; end
        end else if (op == 1) begin
            if (c + amt > CMAX) st = 3;
            else begin st = 0; bal = c + amt; wr = 1'b1; end
        end else if (op == 2) begin
            st = 0;
        end
    endfunction

    // Compare process: every cycle, outputs against the model of the outstanding transaction.
    initial begin : monitor
        int     cyc, acc_cyc, k, e_st, e_acct;
        longint e_bal;
        bit     e_wr, busy;
        logic [39:0] e_rec;
        cyc = 0; acc_cyc = 0; busy = 0; e_st = 0; e_acct = 0; e_bal = 0; e_wr = 0; e_rec = '0;
        for (int i = 0; i < NACCT; i++) begin
            lim[i]  = 15'($urandom_range(0, 32767));
            cred[i] = 25'($urandom_range(0, 33554431));
        end
        lim[5] = 15'd1000; cred[5] = 25'd5000;
        lim[6] = 15'd1000; cred[6] = 25'd300;
        lim[7] = 15'd1000; cred[7] = 25'd1;
        forever begin
            @(negedge clk);
            cyc++;
            if (!rst_n) begin
                chk("rst_ctrl", {req_ready, resp_valid, ram_write_enable, resp_status, ram_address},
                    11'b100_00_000000);
                chk("rst_balance", resp_balance, 0);
                chk("rst_wdata", ram_data_in, 0);
                busy = 0;
            end else if (busy) begin
                k = cyc - acc_cyc;
                chk("busy_ctrl", {req_ready, resp_valid, ram_write_enable},
                    {1'b0, k >= 4, (k == 3) && e_wr});
                if (k == 1 || (k == 3 && e_wr)) chk("ram_addr", ram_address, e_acct);
                if (k == 3 && e_wr) chk("ram_wdata", ram_data_in, e_rec);
                if (k == 4 && e_wr) cred[e_acct] = 25'(e_bal);
                if (k >= 4) begin
                    chk("resp_status", resp_status, e_st);
                    chk("resp_balance", resp_balance, e_bal);
                    if (resp_ready) busy = 0;
                end
            end else begin
                chk("idle_ctrl", {req_ready, resp_valid, ram_write_enable}, 3'b100);
                if (req_valid && req_ready) begin
                    model_txn(int'(req_op), int'(req_acct), longint'(req_amount), e_st, e_bal, e_wr);
                    e_acct  = int'(req_acct);
                    e_rec   = {lim[e_acct], 25'(e_bal)};
                    busy    = 1;
                    acc_cyc = cyc;
                end
            end
        end
    end

    // Response consumer: holds resp_ready low for resp_hold cycles, then captures.
    int resp_hold = 0;
    int got_st[$];
    longint got_bal[$];
    initial begin : consumer
        int hold_cnt = 0;
        resp_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (resp_valid && rst_n) begin
                if (hold_cnt < resp_hold) begin
                    hold_cnt++;
                    resp_ready = 1'b0;
                end else if (!resp_ready) begin
                    resp_ready = 1'b1;
                    got_st.push_back(int'(resp_status));
                    got_bal.push_back(longint'(resp_balance));
                end
            end else begin
                resp_ready = 1'b0;
                hold_cnt   = 0;
            end
        end
    end

    task automatic send(input int op, input int acct, input longint amt);
        int n = 0;
        @(posedge clk);
        #1;
        req_op     = 2'(op);
        req_acct   = 6'(acct);
        req_amount = 25'(amt);
        req_valid  = 1'b1;
        do begin
            @(negedge clk);
            n++;
        end while (!req_ready && n < 100);
        if (!req_ready) begin
            checks++; errors++;
            $display("FAIL req_accept_timeout: req_ready=%0b required 1", req_ready);
        end
        @(posedge clk);
        #1;
        req_valid = 1'b0;
    endtask

    task automatic get_resp(output int st, output longint bal);
        int n = 0;
        while (got_st.size() == 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (got_st.size() == 0) begin
            checks++; errors++;
            $display("FAIL resp_timeout: no response seen, required one");
            st = -1; bal = -1;
        end else begin
            st  = got_st.pop_front();
            bal = got_bal.pop_front();
        end
    endtask

    task automatic txn(input int op, input int acct, input longint amt,
                       output int st, output longint bal);
        send(op, acct, amt);
        get_resp(st, bal);
    endtask

    initial begin : stimulus
        int     st;
        longint bal, v;
        int     op, a;
        rst_n = 1'b0; preload = 1'b1;
        req_valid = 1'b0; req_op = '0; req_acct = '0; req_amount = '0;
        repeat (3) @(negedge clk);
        preload = 1'b0;
        rst_n   = 1'b1;

        // T1: plain withdraw
        txn(0, 5, 700, st, bal);
        chk("t1_status", st, 0);
        chk("t1_balance", bal, 4300);
        chk("t1_record", mem[5], {15'd1000, 25'd4300});
        // T2: over limit, then inquiry
        txn(0, 5, 1500, st, bal);
        chk("t2_status", st, 2);
        chk("t2_balance", bal, 4300);
        txn(2, 5, 123, st, bal);
        chk("t2_inq_status", st, 0);
        chk("t2_inq_balance", bal, 4300);
        chk("t2_record", mem[5], {15'd1000, 25'd4300});
        // T3: insufficient, exact credit, zero amount
        txn(0, 6, 301, st, bal);
        chk("t3a_status", st, 1);
        chk("t3a_balance", bal, 300);
        txn(0, 6, 300, st, bal);
        chk("t3b_status", st, 0);
        chk("t3b_balance", bal, 0);
        txn(0, 6, 0, st, bal);
        chk("t3c_status", st, 0);
        chk("t3c_balance", bal, 0);
        // T4: deposit overflow, normal deposit, reserved op
        txn(1, 7, CMAX, st, bal);
        chk("t4a_status", st, 3);
        chk("t4a_balance", bal, 1);
        txn(1, 7, 99, st, bal);
        chk("t4b_status", st, 0);
        chk("t4b_balance", bal, 100);
        txn(3, 7, 5, st, bal);
        chk("t4c_status", st, 3);
        chk("t4c_balance", bal, 100);
        // T5: back-to-back with a stalled consumer
        resp_hold = 5;
        send(0, 5, 700);
        send(0, 5, 700);
        get_resp(st, bal);
        chk("t5a_status", st, 0);
        chk("t5a_balance", bal, 3600);
        get_resp(st, bal);
        chk("t5b_status", st, 0);
        chk("t5b_balance", bal, 2900);
        resp_hold = 0;
        // T6: reset while the write strobe is up
        send(0, 5, 700);
        @(posedge clk);
        @(posedge clk);
        #1;
        chk("t6_we_before", ram_write_enable, 1);
        rst_n = 1'b0;
        #1;
        chk("t6_rst_ctrl", {ram_write_enable, req_ready, resp_valid}, 3'b010);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        chk("t6_ready_after", req_ready, 1);
        txn(2, 5, 0, st, bal);
        chk("t6_status", st, 0);
        chk("t6_old_or_new", (bal == 2900 || bal == 2200) ? 1 : 0, 1);

        // Randomized transactions on a small set of accounts, biased to boundaries.
        repeat (300) begin
            op = ($urandom_range(0, 9) < 5) ? 0 : int'($urandom_range(1, 3));
            a  = int'($urandom_range(0, 9));
            case ($urandom_range(0, 7))
                0: v = 0;
                1: v = longint'(lim[a]);
                2: v = longint'(lim[a]) + 1;
                3: v = longint'(cred[a]);
                4: v = longint'(cred[a]) + 1;
                5: v = CMAX + 1 - longint'(cred[a]);
                6: v = CMAX - longint'(cred[a]);
                default: v = longint'($urandom_range(0, 33554431));
            endcase
            if (v > CMAX) v = CMAX;
            resp_hold = int'($urandom_range(0, 3));
            txn(op, a, v, st, bal);
            repeat ($urandom_range(0, 2)) @(posedge clk);
        end
        repeat (3) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
